// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port memory arbiter.
package mem_arb_pkg;

   typedef enum logic [1:0] {IDLE, IBUSY, DBUSY, RESP} state_t;
   typedef enum logic {INST, DATA} grant_t;

   // Wide enough for any data width in use; consumers slice to DATA_W.
   localparam logic [63:0] ERR_DATA    = {64{1'b1}};
   localparam int          TIMEOUT_DEF = 15;

endpackage

// File: rtl/mem_arbiter_if.sv
// Unified memory bus: the arbiter is the master, the memory is the slave.
interface mem_arbiter_if #(
   parameter int ADDR_W = 16,
   parameter int DATA_W = 16
);
   logic              mem_req;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;
   logic              mem_rdy;

   modport master (
      output mem_req, mem_we, mem_addr, mem_wdata,
      input  mem_rdata, mem_rdy
   );

   modport slave (
      input  mem_req, mem_we, mem_addr, mem_wdata,
      output mem_rdata, mem_rdy
   );
endinterface

// File: rtl/mem_arb_timer.sv
// Saturating bus-wait counter; expire flags the last permitted wait cycle.
module mem_arb_timer #(
   parameter int LIMIT = 15
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   input  logic en,
   output logic expire
);
   localparam int             W    = $clog2(LIMIT + 1);
   localparam logic [W-1:0]   LAST = W'(LIMIT - 1);
   localparam logic [W-1:0]   MAX  = W'(LIMIT);

   logic [W-1:0] count;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else if (clr) begin
         count <= '0;
      end else if (en && count != MAX) begin
         count <= count + 1'b1;
      end
   end

   // Expire is raised while the count sits on its final cycle so the abort lands exactly at LIMIT.
   assign expire = (count >= LAST);

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter between instruction fetch and data load/store over one
// ready-handshaked memory, with a bus timeout and a sticky error flag.
import mem_arb_pkg::*;

module mem_arbiter #(
   parameter int ADDR_W  = 16,
   parameter int DATA_W  = 16,
   parameter int TIMEOUT = TIMEOUT_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              hlt,
   input  logic              i_req,
   input  logic [ADDR_W-1:0] i_addr,
   output logic [DATA_W-1:0] i_rdata,
   output logic              i_ack,
   input  logic              d_re,
   input  logic              d_we,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [DATA_W-1:0] d_wdata,
   output logic [DATA_W-1:0] d_rdata,
   output logic              d_ack,
   mem_arbiter_if.master     mem,
   output logic              stall,
   output logic              err
);
   state_t            state, state_n;
   grant_t            last_grant, last_n;
   logic              dreq, ireq;
   logic              req_n, we_n, iack_n, dack_n, err_n;
   logic [ADDR_W-1:0] addr_n;
   logic [DATA_W-1:0] wdata_n, irdata_n, drdata_n;
   logic              tmr_clr, tmr_en, tmr_expire;

   assign dreq  = d_re | d_we;
   assign ireq  = i_req & ~hlt;
   assign stall = (i_req & ~i_ack & ~hlt) | (dreq & ~d_ack);

   mem_arb_timer #(.LIMIT(TIMEOUT)) u_timer (
      .clk    (clk),
      .rst_n  (rst_n),
      .clr    (tmr_clr),
      .en     (tmr_en),
      .expire (tmr_expire)
   );

   // State and every registered output update together from the next-state logic below.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= IDLE;
         last_grant    <= INST;
         mem.mem_req   <= 1'b0;
         mem.mem_we    <= 1'b0;
         mem.mem_addr  <= '0;
         mem.mem_wdata <= '0;
         i_rdata       <= '0;
         d_rdata       <= '0;
         i_ack         <= 1'b0;
         d_ack         <= 1'b0;
         err           <= 1'b0;
      end else begin
         state         <= state_n;
         last_grant    <= last_n;
         mem.mem_req   <= req_n;
         mem.mem_we    <= we_n;
         mem.mem_addr  <= addr_n;
         mem.mem_wdata <= wdata_n;
         i_rdata       <= irdata_n;
         d_rdata       <= drdata_n;
         i_ack         <= iack_n;
         d_ack         <= dack_n;
         err           <= err_n;
      end
   end

   // Grant on contention goes to whoever was not served last; RESP never grants.
   always_comb begin
      state_n  = state;
      last_n   = last_grant;
      req_n    = mem.mem_req;
      we_n     = mem.mem_we;
      addr_n   = mem.mem_addr;
      wdata_n  = mem.mem_wdata;
      irdata_n = i_rdata;
      drdata_n = d_rdata;
      iack_n   = 1'b0;
      dack_n   = 1'b0;
      err_n    = err;
      tmr_clr  = 1'b0;
      tmr_en   = 1'b0;
      case (state)
         IDLE: begin
            if (dreq && (!ireq || last_grant == INST)) begin
               state_n = DBUSY;
               last_n  = DATA;
               req_n   = 1'b1;
               we_n    = d_we;
               addr_n  = d_addr;
               wdata_n = d_wdata;
               tmr_clr = 1'b1;
               if (d_re && d_we) err_n = 1'b1;
            end else if (ireq) begin
               state_n = IBUSY;
               last_n  = INST;
               req_n   = 1'b1;
               we_n    = 1'b0;
               addr_n  = i_addr;
               wdata_n = '0;
               tmr_clr = 1'b1;
            end
         end
         IBUSY, DBUSY: begin
            if (mem.mem_rdy || tmr_expire) begin
               state_n = RESP;
               req_n   = 1'b0;
               if (!mem.mem_rdy) err_n = 1'b1;
               if (state == IBUSY) begin
                  iack_n   = 1'b1;
                  irdata_n = mem.mem_rdy ? mem.mem_rdata : ERR_DATA[DATA_W-1:0];
               end else begin
                  dack_n = 1'b1;
                  if (!mem.mem_we) drdata_n = mem.mem_rdy ? mem.mem_rdata : ERR_DATA[DATA_W-1:0];
               end
            end else begin
               tmr_en = 1'b1;
            end
         end
         RESP:    state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scenario bench for mem_arbiter: a simple memory responder plus an ack scoreboard.
module tb_mem_arbiter;
   localparam int AW = 16;
   localparam int DW = 16;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          hlt = 1'b0, i_req = 1'b0, d_re = 1'b0, d_we = 1'b0;
   logic [AW-1:0] i_addr = '0, d_addr = '0;
   logic [DW-1:0] d_wdata = '0;
   logic [DW-1:0] i_rdata, d_rdata;
   logic          i_ack, d_ack, stall, err;

   mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) mif ();

   mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(15)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .hlt     (hlt),
      .i_req   (i_req),
      .i_addr  (i_addr),
      .i_rdata (i_rdata),
      .i_ack   (i_ack),
      .d_re    (d_re),
      .d_we    (d_we),
      .d_addr  (d_addr),
      .d_wdata (d_wdata),
      .d_rdata (d_rdata),
      .d_ack   (d_ack),
      .mem     (mif),
      .stall   (stall),
      .err     (err)
   );

   always #5 clk = ~clk;

   int vectors = 0;
   int miscompares = 0;

   typedef struct packed {
      logic          is_data;
      logic [DW-1:0] rdata;
   } exp_t;
   exp_t sb[$];

   int            mem_wait = 0;
   bit            mem_dead = 1'b0;
   bit            use_fixed = 1'b0;
   logic [DW-1:0] fixed_data = '0;
   int            rcnt = 0;

   function automatic logic [DW-1:0] mem_val(input logic [AW-1:0] a);
      return a ^ 16'hC3A5;
   endfunction

   // Memory: answers after mem_wait cycles of mem_req, or never while mem_dead.
   initial begin
      mif.mem_rdy   = 1'b0;
      mif.mem_rdata = '0;
   end
   always @(negedge clk) begin
      if (mif.mem_req) begin
         if (!mem_dead && rcnt == mem_wait) begin
            mif.mem_rdy   = 1'b1;
            mif.mem_rdata = use_fixed ? fixed_data : mem_val(mif.mem_addr);
         end else begin
            mif.mem_rdy = 1'b0;
         end
         rcnt++;
      end else begin
         mif.mem_rdy = 1'b0;
         rcnt = 0;
      end
   end

   task automatic wait_ack(input int bound, output int n);
      n = -1;
      for (int k = 1; k <= bound; k++) begin
         @(negedge clk);
         if (i_ack || d_ack) begin
            n = k;
            break;
         end
      end
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      hlt = 1'b0; i_req = 1'b0; d_re = 1'b0; d_we = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      vectors++; if (mif.mem_req !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_mem_req got %b want 0", mif.mem_req); end
      vectors++; if (mif.mem_we !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_mem_we got %b want 0", mif.mem_we); end
      vectors++; if (mif.mem_addr !== 16'h0) begin miscompares++; $display("[TB] FAIL rst_mem_addr got %h want 0000", mif.mem_addr); end
      vectors++; if (mif.mem_wdata !== 16'h0) begin miscompares++; $display("[TB] FAIL rst_mem_wdata got %h want 0000", mif.mem_wdata); end
      vectors++; if (i_rdata !== 16'h0) begin miscompares++; $display("[TB] FAIL rst_i_rdata got %h want 0000", i_rdata); end
      vectors++; if (d_rdata !== 16'h0) begin miscompares++; $display("[TB] FAIL rst_d_rdata got %h want 0000", d_rdata); end
      vectors++; if ({i_ack, d_ack} !== 2'b00) begin miscompares++; $display("[TB] FAIL rst_acks got %b want 00", {i_ack, d_ack}); end
      vectors++; if (err !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_err got %b want 0", err); end
      vectors++; if (stall !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_stall got %b want 0", stall); end
      rst_n = 1'b1;
      @(negedge clk);
      vectors++; if (mif.mem_req !== 1'b0) begin miscompares++; $display("[TB] FAIL idle_mem_req got %b want 0", mif.mem_req); end
   endtask

   task automatic test_contention();
      exp_t e;
      do_reset();
      mem_wait = 0;
      e.is_data = 1'b1; e.rdata = mem_val(16'h0040); sb.push_back(e);
      e.is_data = 1'b0; e.rdata = mem_val(16'h0030); sb.push_back(e);
      e.is_data = 1'b1; e.rdata = mem_val(16'h0042); sb.push_back(e);
      i_req = 1'b1; i_addr = 16'h0030; d_re = 1'b1; d_addr = 16'h0040;
      @(negedge clk);
      vectors++; if ({mif.mem_req, mif.mem_addr} !== {1'b1, 16'h0040}) begin miscompares++; $display("[TB] FAIL cont1_grant got %b/%h want 1/0040", mif.mem_req, mif.mem_addr); end
      @(negedge clk);
      vectors++;
      if (sb.size() == 0) begin miscompares++; $display("[TB] FAIL cont1_ack scoreboard empty"); end
      else begin
         e = sb.pop_front();
         if ({d_ack, i_ack, d_rdata} !== {e.is_data, !e.is_data, e.rdata}) begin miscompares++; $display("[TB] FAIL cont1_ack got d%b i%b %h want d%b i%b %h", d_ack, i_ack, d_rdata, e.is_data, !e.is_data, e.rdata); end
      end
      d_addr = 16'h0042;
      repeat (2) @(negedge clk);
      vectors++; if ({mif.mem_req, mif.mem_addr} !== {1'b1, 16'h0030}) begin miscompares++; $display("[TB] FAIL cont2_rr_grant got %b/%h want 1/0030", mif.mem_req, mif.mem_addr); end
      @(negedge clk);
      vectors++;
      if (sb.size() == 0) begin miscompares++; $display("[TB] FAIL cont2_ack scoreboard empty"); end
      else begin
         e = sb.pop_front();
         if ({d_ack, i_ack, i_rdata} !== {e.is_data, !e.is_data, e.rdata}) begin miscompares++; $display("[TB] FAIL cont2_ack got d%b i%b %h want d%b i%b %h", d_ack, i_ack, i_rdata, e.is_data, !e.is_data, e.rdata); end
      end
      i_req = 1'b0;
      repeat (2) @(negedge clk);
      vectors++; if ({mif.mem_req, mif.mem_addr} !== {1'b1, 16'h0042}) begin miscompares++; $display("[TB] FAIL cont3_grant got %b/%h want 1/0042", mif.mem_req, mif.mem_addr); end
      @(negedge clk);
      vectors++;
      if (sb.size() == 0) begin miscompares++; $display("[TB] FAIL cont3_ack scoreboard empty"); end
      else begin
         e = sb.pop_front();
         if ({d_ack, i_ack, d_rdata} !== {e.is_data, !e.is_data, e.rdata}) begin miscompares++; $display("[TB] FAIL cont3_ack got d%b i%b %h want d%b i%b %h", d_ack, i_ack, d_rdata, e.is_data, !e.is_data, e.rdata); end
      end
      d_re = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_fetch();
      exp_t e;
      mem_wait = 0; use_fixed = 1'b1; fixed_data = 16'hB123;
      e.is_data = 1'b0; e.rdata = 16'hB123; sb.push_back(e);
      i_req = 1'b1; i_addr = 16'h0010;
      #1;
      vectors++; if ({stall, mif.mem_req} !== 2'b10) begin miscompares++; $display("[TB] FAIL fetch_c0 stall/req got %b want 10", {stall, mif.mem_req}); end
      @(negedge clk);
      vectors++; if ({stall, mif.mem_req, mif.mem_we, mif.mem_addr} !== {3'b110, 16'h0010}) begin miscompares++; $display("[TB] FAIL fetch_c1 got %b%b%b %h want 110 0010", stall, mif.mem_req, mif.mem_we, mif.mem_addr); end
      @(negedge clk);
      vectors++; if ({stall, mif.mem_req} !== 2'b00) begin miscompares++; $display("[TB] FAIL fetch_c2 stall/req got %b want 00", {stall, mif.mem_req}); end
      vectors++;
      if (sb.size() == 0) begin miscompares++; $display("[TB] FAIL fetch_ack scoreboard empty"); end
      else begin
         e = sb.pop_front();
         if ({d_ack, i_ack, i_rdata} !== {e.is_data, !e.is_data, e.rdata}) begin miscompares++; $display("[TB] FAIL fetch_ack got d%b i%b %h want d%b i%b %h", d_ack, i_ack, i_rdata, e.is_data, !e.is_data, e.rdata); end
      end
      i_req = 1'b0; use_fixed = 1'b0;
      @(negedge clk);
      vectors++; if (i_ack !== 1'b0) begin miscompares++; $display("[TB] FAIL fetch_ack_pulse got %b want 0", i_ack); end
   endtask

   task automatic test_store();
      exp_t e;
      mem_wait = 3;
      e.is_data = 1'b1; e.rdata = mem_val(16'h0042); sb.push_back(e);
      d_we = 1'b1; d_addr = 16'h0022; d_wdata = 16'h5A5A;
      for (int c = 1; c <= 4; c++) begin
         @(negedge clk);
         vectors++;
         if ({mif.mem_req, mif.mem_we, mif.mem_addr, mif.mem_wdata, d_ack} !== {2'b11, 16'h0022, 16'h5A5A, 1'b0}) begin
            miscompares++;
            $display("[TB] FAIL store_hold c%0d got req%b we%b %h %h ack%b want 1 1 0022 5a5a 0", c, mif.mem_req, mif.mem_we, mif.mem_addr, mif.mem_wdata, d_ack);
         end
      end
      @(negedge clk);
      vectors++;
      if (sb.size() == 0) begin miscompares++; $display("[TB] FAIL store_ack scoreboard empty"); end
      else begin
         e = sb.pop_front();
         if ({d_ack, i_ack, d_rdata, mif.mem_req} !== {e.is_data, !e.is_data, e.rdata, 1'b0}) begin miscompares++; $display("[TB] FAIL store_ack got d%b i%b %h req%b want d%b i%b %h req0", d_ack, i_ack, d_rdata, mif.mem_req, e.is_data, !e.is_data, e.rdata); end
      end
      d_we = 1'b0;
      @(negedge clk);
      vectors++; if ({d_ack, err} !== 2'b00) begin miscompares++; $display("[TB] FAIL store_after got ack%b err%b want 0 0", d_ack, err); end
   endtask

   task automatic test_hlt();
      exp_t e;
      int   n;
      mem_wait = 0;
      hlt = 1'b1; i_req = 1'b1; i_addr = 16'h0070;
      #1;
      vectors++; if (stall !== 1'b0) begin miscompares++; $display("[TB] FAIL hlt_stall got %b want 0", stall); end
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         vectors++; if (mif.mem_req !== 1'b0) begin miscompares++; $display("[TB] FAIL hlt_no_grant c%0d got %b want 0", c, mif.mem_req); end
      end
      e.is_data = 1'b1; e.rdata = mem_val(16'h0044); sb.push_back(e);
      d_re = 1'b1; d_addr = 16'h0044;
      wait_ack(10, n);
      vectors++;
      if (n != 2 || sb.size() == 0) begin miscompares++; $display("[TB] FAIL hlt_data_latency got %0d want 2", n); end
      else begin
         e = sb.pop_front();
         if ({d_ack, i_ack, d_rdata} !== {e.is_data, !e.is_data, e.rdata}) begin miscompares++; $display("[TB] FAIL hlt_data_ack got d%b i%b %h want d%b i%b %h", d_ack, i_ack, d_rdata, e.is_data, !e.is_data, e.rdata); end
      end
      d_re = 1'b0; mem_wait = 3; hlt = 1'b0;
      e.is_data = 1'b0; e.rdata = mem_val(16'h0070); sb.push_back(e);
      repeat (2) @(negedge clk);
      vectors++; if ({mif.mem_req, mif.mem_addr} !== {1'b1, 16'h0070}) begin miscompares++; $display("[TB] FAIL hlt_fetch_grant got %b/%h want 1/0070", mif.mem_req, mif.mem_addr); end
      hlt = 1'b1;
      wait_ack(10, n);
      vectors++;
      if (n != 4 || sb.size() == 0) begin miscompares++; $display("[TB] FAIL hlt_inflight_latency got %0d want 4", n); end
      else begin
         e = sb.pop_front();
         if ({d_ack, i_ack, i_rdata} !== {e.is_data, !e.is_data, e.rdata}) begin miscompares++; $display("[TB] FAIL hlt_inflight_ack got d%b i%b %h want d%b i%b %h", d_ack, i_ack, i_rdata, e.is_data, !e.is_data, e.rdata); end
      end
      i_req = 1'b0; hlt = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_timeout();
      exp_t e;
      int   hi;
      mem_dead = 1'b1; mem_wait = 0;
      e.is_data = 1'b1; e.rdata = 16'hFFFF; sb.push_back(e);
      d_re = 1'b1; d_addr = 16'h0050;
      hi = 0;
      @(negedge clk);
      while (mif.mem_req === 1'b1 && hi < 40) begin
         hi++;
         @(negedge clk);
      end
      vectors++; if (hi != 15) begin miscompares++; $display("[TB] FAIL timeout_req_cycles got %0d want 15", hi); end
      vectors++;
      if (sb.size() == 0) begin miscompares++; $display("[TB] FAIL timeout_ack scoreboard empty"); end
      else begin
         e = sb.pop_front();
         if ({d_ack, i_ack, d_rdata, err} !== {e.is_data, !e.is_data, e.rdata, 1'b1}) begin miscompares++; $display("[TB] FAIL timeout_ack got d%b i%b %h err%b want d%b i%b %h err1", d_ack, i_ack, d_rdata, err, e.is_data, !e.is_data, e.rdata); end
      end
      d_re = 1'b0; mem_dead = 1'b0;
      repeat (3) @(negedge clk);
      vectors++; if ({err, d_ack} !== 2'b10) begin miscompares++; $display("[TB] FAIL timeout_err_sticky got err%b ack%b want 1 0", err, d_ack); end
   endtask

   task automatic test_reset_mid();
      exp_t e;
      int   n;
      mem_dead = 1'b1; mem_wait = 0;
      d_re = 1'b1; d_addr = 16'h0060;
      @(negedge clk);
      vectors++; if (mif.mem_req !== 1'b1) begin miscompares++; $display("[TB] FAIL rmid_busy got %b want 1", mif.mem_req); end
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      vectors++; if ({mif.mem_req, err, d_ack} !== 3'b000) begin miscompares++; $display("[TB] FAIL rmid_abort got req%b err%b ack%b want 000", mif.mem_req, err, d_ack); end
      @(negedge clk);
      vectors++; if (d_ack !== 1'b0) begin miscompares++; $display("[TB] FAIL rmid_no_ack got %b want 0", d_ack); end
      mem_dead = 1'b0;
      e.is_data = 1'b1; e.rdata = mem_val(16'h0060); sb.push_back(e);
      rst_n = 1'b1;
      wait_ack(10, n);
      vectors++;
      if (n != 2 || sb.size() == 0) begin miscompares++; $display("[TB] FAIL rmid_regrant_latency got %0d want 2", n); end
      else begin
         e = sb.pop_front();
         if ({d_ack, i_ack, d_rdata} !== {e.is_data, !e.is_data, e.rdata}) begin miscompares++; $display("[TB] FAIL rmid_regrant_ack got d%b i%b %h want d%b i%b %h", d_ack, i_ack, d_rdata, e.is_data, !e.is_data, e.rdata); end
      end
      d_re = 1'b0;
      @(negedge clk);
   endtask

   initial begin
      test_reset();
      test_contention();
      test_fetch();
      test_store();
      test_hlt();
      test_timeout();
      test_reset_mid();
      vectors++; if (sb.size() != 0) begin miscompares++; $display("[TB] FAIL scoreboard_leftover got %0d want 0", sb.size()); end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #100000;
      $display("[TB] FAIL watchdog expired got running want finished");
      $fatal(1, "[TB] watchdog");
   end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Arbitrates a single unified, multi-cycle, ready-handshaked memory between two requesters: the CPU instruction-fetch port and the data load/store port.
- Serialises accesses and registers the returned read data.
- Generates the CPU stall signal.
- Enforces a bus timeout so the pipeline cannot hang on a dead memory.

Parameters:
- ADDR_W, 16, address width.
- DATA_W, 16, data width.
- TIMEOUT, 15, max cycles mem_req may stay high without mem_rdy before abort (1..255).

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- hlt  in  1  CPU halted; blocks new instruction grants.
- i_req  in  1  fetch request (level, held until i_ack).
- i_addr  in  ADDR_W  fetch address.
- i_rdata  out  DATA_W  fetched instruction, valid when i_ack=1.
- i_ack  out  1  one-cycle fetch-complete pulse.
- d_re  in  1  load request (level).
- d_we  in  1  store request (level).
- d_addr  in  ADDR_W  data address.
- d_wdata  in  DATA_W  store data.
- d_rdata  out  DATA_W  load data, valid when d_ack=1.
- d_ack  out  1  one-cycle data-complete pulse.
- mem_req  out  1  memory access strobe.
- mem_we  out  1  memory write enable.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data, valid with mem_rdy.
- mem_rdy  in  1  memory done.
- stall  out  1  freeze CPU pc/pipeline.
- err  out  1  sticky error flag.

Behaviour:
- Reset (async, rst_n=0): state IDLE; mem_req, mem_we, i_ack, d_ack, err all 0; mem_addr, mem_wdata, i_rdata, d_rdata all 0; last_grant=INST; timer 0.
- FSM states are IDLE, IBUSY, DBUSY, RESP.
- IDLE grant decision:
  - Data request present is dreq = d_re|d_we; instruction request present is ireq = i_req & !hlt.
  - dreq only: go to DBUSY.
  - ireq only: go to IBUSY.
  - Both: go to IBUSY if last_grant==DATA, else DBUSY (round-robin on contention; data wins the first contention after reset).
  - On grant, register mem_addr, mem_we (=d_we for data, 0 for fetch) and mem_wdata; set mem_req=1 from the next cycle; update last_grant.
- IBUSY/DBUSY:
  - mem_req, mem_addr, mem_we and mem_wdata are held stable.
  - On mem_rdy=1:
    - Capture mem_rdata into i_rdata (fetch) or d_rdata (load); a store leaves d_rdata unchanged.
    - Drop mem_req and go to RESP.
- RESP lasts one cycle:
  - Pulse the matching ack.
  - No grant is made, so a requester still holding its request during the ack cycle is not re-granted.
  - Then return to IDLE.
- Latency: request seen in IDLE at cycle 0, mem_req=1 at cycle 1, ack at cycle 2 if mem_rdy arrives at cycle 1. Each extra memory wait cycle adds 1.
- Timeout:
  - The timer counts cycles in a BUSY state with mem_rdy=0.
  - When the count reaches TIMEOUT: drop mem_req, load all-ones into the rdata register (fetch or load), set err, go to RESP and ack normally.
  - The timer clears on entry to each BUSY state.
- Illegal request: d_re & d_we together is treated as a store and sets err.
- err stays set until reset.
- hlt:
  - An in-flight fetch completes normally.
  - While hlt=1 no new fetch is granted; data grants are unaffected.
- stall = (i_req & !i_ack & !hlt) | ((d_re|d_we) & !d_ack), combinational.
- mem_rdy outside a BUSY state is ignored.
- Reset asserted mid-transaction aborts immediately: mem_req=0, no ack.

Decomposition:
- Shared package mem_arb_pkg holds:
  - state enum {IDLE, IBUSY, DBUSY, RESP};
  - grant enum {INST, DATA};
  - ERR_DATA constant (all ones);
  - TIMEOUT default.
- Sub-module mem_arb_timer: loadable saturating cycle counter with clear and expire output. Timer width is $clog2(TIMEOUT+1).

Test Plan:
- Fetch only, i_addr=0x0010, mem_rdy one cycle after mem_req, mem_rdata=0xB123 -> mem_req at cycle 1, i_ack at cycle 2, i_rdata=0xB123, stall high on cycles 0-1, low on cycle 2.
- i_req and d_re both raised at cycle 0 after reset, d_addr=0x0040 -> data granted first and d_ack fires; then the fetch is granted. Second simultaneous pair -> fetch granted first (round-robin).
- Store: d_we=1, d_addr=0x0022, d_wdata=0x5A5A, mem_rdy after 3 wait cycles -> mem_we=1, mem_wdata=0x5A5A held for 4 cycles, d_ack once, d_rdata unchanged.
- Load with mem_rdy never asserted, TIMEOUT=15 -> mem_req drops after 15 cycles, d_ack pulses, d_rdata=0xFFFF, err=1 and stays 1.
- hlt=1 with i_req held -> no fetch grant and stall=0. A fetch in flight when hlt rises completes with i_ack.
- rst_n pulsed low mid-DBUSY -> mem_req=0 and err=0 immediately, no ack, next grant taken from IDLE.
